button_conditioner: RTL and testbench

- Conditions raw board push-buttons before they reach the operation multiplexer and display scanner.
- Per button, it performs 2-flop synchronisation, counter-based debounce, press/release edge detection and optional hold-to-repeat.
- Its outputs replace the raw enable/clear button wires: a single clean pulse per physical press.
- Runs on the board system clock, upstream of the clock divider and operation mux.

---
 rtl/alu_board_pkg.sv | 15 +
 rtl/button_channel.sv | 129 ++++++++++++
 rtl/button_conditioner.sv | 35 +++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_board_pkg.sv
// Shared board-level types and constants for the ALU demo board front end.
package alu_board_pkg;

    localparam int unsigned SYS_CLK_HZ              = 100_000_000;
    // 10 ms of stable input at the system clock rate
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = SYS_CLK_HZ / 100;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, debounce FSM, edge pulses and hold-to-repeat.
module button_channel
    import alu_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_LIM = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_LIM) + 1;
    localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_WRAP  = HOLD_W'(HOLD_LIM);

    logic              sync1, sync2;
    btn_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign hold_inc = hold_q + 1'b1;

    // Next-state and next-output logic; FSM only ever looks at sync2
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            RELEASED: begin
                if (sync2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    // hold climbs to the first-repeat point, then cycles through one period
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_FIRST) begin
                        repeat_d = 1'b1;
                    end else if (hold_inc == HOLD_WRAP) begin
                        repeat_d = 1'b1;
                        hold_d   = HOLD_FIRST;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw board buttons into clean level, press, release and repeat signals.
module button_conditioner
    import alu_board_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one instance with repeat enabled, one without.
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_raw = 2'b00;

    logic [1:0] lvl_a, prs_a, rel_a, rep_a;
    logic [1:0] lvl_b, prs_b, rel_b, rep_b;

    always #5 clock = ~clock;

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) u_dut_rep (
        .clock(clock), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rep_a)
    );

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
    ) u_dut_norep (
        .clock(clock), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rep_b)
    );

    int checks   = 0;
    int failures = 0;

    // per [dut][channel] statistics; dut 0 = repeat enabled, dut 1 = repeat disabled
    int press_n [2][2];
    int rel_n   [2][2];
    int rep_n   [2][2];
    int first_press [2][2];
    int first_rel   [2][2];
    int first_rep   [2][2];
    int second_rep  [2][2];
    int lvl_lo  [2][2];
    int lvl_hi  [2][2];
    int base = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tally(input int d, input int e, input logic [1:0] lv,
                         input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp);
        for (int c = 0; c < 2; c++) begin
            if (pr[c]) begin
                press_n[d][c]++;
                if (first_press[d][c] == 0) first_press[d][c] = e;
            end
            if (rl[c]) begin
                rel_n[d][c]++;
                if (first_rel[d][c] == 0) first_rel[d][c] = e;
            end
            if (rp[c]) begin
                rep_n[d][c]++;
                if (first_rep[d][c] == 0) first_rep[d][c] = e;
                else if (second_rep[d][c] == 0) second_rep[d][c] = e;
            end
            if (!lv[c]) lvl_lo[d][c] = 0;
            if (lv[c])  lvl_hi[d][c] = 1;
        end
    endtask

    // Step n clock edges, sampling 1 time unit after each rising edge
    task automatic window(input int n, input bit clr);
        if (clr) begin
            base = 0;
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    press_n[d][c] = 0; rel_n[d][c] = 0; rep_n[d][c] = 0;
                    first_press[d][c] = 0; first_rel[d][c] = 0;
                    first_rep[d][c] = 0; second_rep[d][c] = 0;
                    lvl_lo[d][c] = 1; lvl_hi[d][c] = 0;
                end
            end
        end
        for (int i = 1; i <= n; i++) begin
            @(posedge clock);
            #1;
            tally(0, base + i, lvl_a, prs_a, rel_a, rep_a);
            tally(1, base + i, lvl_b, prs_b, rel_b, rep_b);
        end
        base += n;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs_rep",   int'({lvl_a, prs_a, rel_a, rep_a}), 0);
        check("reset_outputs_norep", int'({lvl_b, prs_b, rel_b, rep_b}), 0);
        reset = 1'b1;
        window(5, 1'b1);

        // Clean press and release on channel 0, repeat disabled
        btn_raw = 2'b01;
        window(20, 1'b1);
        check("clean_press_count", press_n[1][0], 1);
        check("clean_press_edge",  first_press[1][0], 7);
        check("clean_level_high",  int'(lvl_b[0]), 1);
        check("clean_no_repeat",   rep_n[1][0], 0);
        check("clean_ch1_press",   press_n[1][1], 0);
        check("clean_ch1_level",   lvl_hi[1][1], 0);
        btn_raw = 2'b00;
        window(12, 1'b1);
        check("clean_release_count", rel_n[1][0], 1);
        check("clean_release_edge",  first_rel[1][0], 7);
        check("clean_level_low",     int'(lvl_b[0]), 0);

        // Bounce: raw toggles every 2 cycles, never stable long enough
        for (int k = 0; k < 10; k++) begin
            btn_raw = (k % 2 == 0) ? 2'b01 : 2'b00;
            window(2, k == 0);
        end
        btn_raw = 2'b00;
        window(12, 1'b0);
        check("bounce_press_rep",     press_n[0][0], 0);
        check("bounce_press_norep",   press_n[1][0], 0);
        check("bounce_release_norep", rel_n[1][0], 0);
        check("bounce_level",         lvl_hi[1][0] + lvl_hi[0][0], 0);

        // Hold-to-repeat on channel 1
        btn_raw = 2'b10;
        window(30, 1'b1);
        check("hold_press_count",  press_n[0][1], 1);
        check("hold_press_edge",   first_press[0][1], 7);
        check("hold_first_repeat", first_rep[0][1], 15);
        check("hold_second_repeat", second_rep[0][1], 18);
        check("hold_repeat_count", rep_n[0][1], 6);
        check("hold_ch0_idle",     press_n[0][0], 0);
        btn_raw = 2'b00;
        window(12, 1'b1);
        check("hold_release_count", rel_n[0][1], 1);
        check("hold_release_edge",  first_rel[0][1], 7);
        check("hold_repeats_stop",  rep_n[0][1], 0);
        check("hold_level_low",     int'(lvl_a[1]), 0);

        // Release glitch: 2-cycle drop while pressed
        btn_raw = 2'b01;
        window(10, 1'b1);
        check("glitch_press_edge", first_press[0][0], 7);
        check("glitch_pre_repeat", rep_n[0][0], 0);
        btn_raw = 2'b00;
        window(2, 1'b1);
        btn_raw = 2'b01;
        window(20, 1'b0);
        check("glitch_no_release",   rel_n[0][0], 0);
        check("glitch_level_held",   lvl_lo[0][0], 1);
        check("glitch_first_repeat", first_rep[0][0], 8);
        check("glitch_repeat_count", rep_n[0][0], 5);
        btn_raw = 2'b00;
        window(12, 1'b1);
        check("glitch_final_release", rel_n[0][0], 1);

        // Asynchronous reset while ch1 pressed and ch0 mid-debounce
        btn_raw = 2'b10;
        window(10, 1'b1);
        check("rst_pre_level", int'(lvl_a), 2);
        btn_raw = 2'b11;
        window(4, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_rep",   int'({lvl_a, prs_a, rel_a, rep_a}), 0);
        check("rst_async_norep", int'({lvl_b, prs_b, rel_b, rep_b}), 0);
        @(posedge clock);
        #1;
        check("rst_held_rep", int'({lvl_a, prs_a, rel_a, rep_a}), 0);
        reset = 1'b1;
        window(10, 1'b1);
        check("rst_ch0_press_edge", first_press[0][0], 7);
        check("rst_ch1_press_edge", first_press[0][1], 7);
        check("rst_ch1_press_count", press_n[0][1], 1);
        check("rst_no_release",     rel_n[0][1], 0);

        // Simultaneous press on both channels
        btn_raw = 2'b00;
        window(15, 1'b1);
        btn_raw = 2'b11;
        window(10, 1'b1);
        check("simul_ch0_edge", first_press[1][0], 7);
        check("simul_ch1_edge", first_press[1][1], 7);
        check("simul_level",    int'(lvl_b), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
